// File: rtl/sc_pkg.sv
// Shared constants for the stochastic arithmetic core: operator encodings,
// FSM states, LFSR seeds and tap positions.
package sc_pkg;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_XNOR = 2'b01;
    localparam logic [1:0] MODE_MUX  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [30:0] SEED_A = 31'd17301504;
    localparam logic [30:0] SEED_B = 31'd268435584;
    localparam logic [30:0] SEED_S = 31'd1431655765;

    // Feedback taps for x^31 + x^28 + 1
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;

endpackage

// File: rtl/sc_lfsr.sv
// Free-running Fibonacci LFSR. It returns to SEED on reset and otherwise
// shifts on every clock edge.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int              LFSR_W = 31,
    parameter logic [LFSR_W-1:0] SEED = {LFSR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else
            state <= {state[LFSR_W-2:0], state[TAP_HI] ^ state[TAP_LO]};
    end

endmodule

// File: rtl/sc_arith_core.sv
// Stochastic-computing arithmetic core: serial operand load, LFSR bitstreams,
// AND/XNOR/MUX operator, windowed ones count. Define SC_ADD_EN for MUX add.
module sc_arith_core
    import sc_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int WIN_LOG2 = 17,
    parameter int LFSR_W   = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             ser_a,
    input  logic             ser_b,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             valid,
    output logic             busy
);

    localparam logic [WIN_LOG2:0] WIN      = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] RUN_LAST = WIN + (WIN_LOG2+1)'(1);

    state_t              state;
    logic [1:0]          mode_q;
    logic [4:0]          load_cnt;
    logic [WIN_LOG2:0]   run_cnt;
    logic [WIN_LOG2:0]   cnt;
    logic [WIN_LOG2:0]   cnt_next;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic                sa, sb, op_bit, op_comb, tag1, tag2;
    logic [LFSR_W-1:0]   lfsr_a;
    logic [LFSR_W-1:0]   lfsr_b;
    logic                unused_bits;

    sc_lfsr #(.LFSR_W(LFSR_W), .SEED(LFSR_W'(SEED_A))) u_lfsr_a (
        .clk(clk), .rst_n(rst_n), .state(lfsr_a));
    sc_lfsr #(.LFSR_W(LFSR_W), .SEED(LFSR_W'(SEED_B))) u_lfsr_b (
        .clk(clk), .rst_n(rst_n), .state(lfsr_b));

`ifdef SC_ADD_EN
    logic [LFSR_W-1:0] lfsr_s;
    sc_lfsr #(.LFSR_W(LFSR_W), .SEED(LFSR_W'(SEED_S))) u_lfsr_s (
        .clk(clk), .rst_n(rst_n), .state(lfsr_s));
    assign unused_bits = ^{lfsr_a[LFSR_W-1:WIDTH], lfsr_b[LFSR_W-1:WIDTH],
                           lfsr_s[LFSR_W-1:1]};
`else
    assign unused_bits = ^{lfsr_a[LFSR_W-1:WIDTH], lfsr_b[LFSR_W-1:WIDTH]};
`endif

    // Mode 11 (and 10 without the adder) falls through to the bipolar multiply
    always_comb begin
        op_comb = ~(sa ^ sb);
        case (mode_q)
            MODE_AND: op_comb = sa & sb;
`ifdef SC_ADD_EN
            MODE_MUX: op_comb = lfsr_s[0] ? sb : sa;
`endif
            default: ;
        endcase
    end

    assign cnt_next = cnt + {{WIN_LOG2{1'b0}}, tag2 & op_bit};
    assign busy     = (state != ST_IDLE);
    assign valid    = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_AND;
            load_cnt <= '0;
            run_cnt  <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        load_cnt <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    op_a     <= {ser_a, op_a[WIDTH-1:1]};
                    op_b     <= {ser_b, op_b[WIDTH-1:1]};
                    load_cnt <= load_cnt + 5'd1;
                    if (load_cnt == 5'(WIDTH-1)) begin
                        run_cnt <= '0;
                        cnt     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    run_cnt <= run_cnt + (WIN_LOG2+1)'(1);
                    cnt     <= cnt_next;
                    // The final tagged bit lands on this edge, so use cnt_next
                    if (run_cnt == RUN_LAST) begin
                        state <= ST_DONE;
                        if (cnt_next == WIN) begin
                            result <= '1;
                            ovf    <= 1'b1;
                        end else begin
                            result <= cnt_next[WIN_LOG2-1 -: WIDTH];
                            ovf    <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Generation and operator stages, each carrying a valid tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= 1'b0;
            sb     <= 1'b0;
            op_bit <= 1'b0;
            tag1   <= 1'b0;
            tag2   <= 1'b0;
        end else begin
            sa     <= (lfsr_a[WIDTH-1:0] < op_a);
            sb     <= (lfsr_b[WIDTH-1:0] < op_b);
            tag1   <= (state == ST_RUN) && (run_cnt < WIN);
            op_bit <= op_comb;
            tag2   <= tag1;
        end
    end

endmodule

// File: tb/tb_sc_arith_core.sv
// Self-checking bench for sc_arith_core (WIDTH=4, WIN_LOG2=8); honours SC_ADD_EN.
module tb_sc_arith_core;

   localparam int W   = 4;
   localparam int N   = 256;
   localparam int LAT = W + N + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       ser_a = 1'b0;
   logic       ser_b = 1'b0;
   logic [3:0] result;
   logic       ovf;
   logic       valid;
   logic       busy;

   int total = 0;
   int bad = 0;
   int ecount;
   int prevResult = 0;
   int prevOvf = 0;

   sc_arith_core #(.WIDTH(W), .WIN_LOG2(8), .LFSR_W(31)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .ser_a(ser_a), .ser_b(ser_b),
      .result(result), .ovf(ovf), .valid(valid), .busy(busy));

   always #5 clk = ~clk;

   // Number of clock edges the free-running LFSRs have taken since reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [30:0] lfsrStep(input logic [30:0] s);
      return {s[29:0], s[30] ^ s[27]};
   endfunction

   // Ones count over the window, given k LFSR steps elapsed before the start edge
   function automatic int modelCount(input logic [1:0] m, input int a, input int b, input int k);
      logic [30:0] la = 31'd17301504;
      logic [30:0] lb = 31'd268435584;
      logic [30:0] ls = 31'd1431655765;
      int c = 0;
      bit x, y, z;
      for (int i = 0; i < k + W + 1; i++) begin
         la = lfsrStep(la);
         lb = lfsrStep(lb);
      end
      for (int i = 0; i < k + W + 2; i++) ls = lfsrStep(ls);
      for (int j = 0; j < N; j++) begin
         x = (la[3:0] < a);
         y = (lb[3:0] < b);
         z = (x == y);
         if (m == 2'b00) z = x & y;
`ifdef SC_ADD_EN
         if (m == 2'b10) z = ls[0] ? y : x;
`endif
         c += int'(z);
         la = lfsrStep(la);
         lb = lfsrStep(lb);
         ls = lfsrStep(ls);
      end
      return c;
   endfunction

   task automatic applyStimulus(input logic [1:0] m, input int a, input int b, input bit noise);
      int k, cnt, expRes, expOvf, c;
      bit seen;
      @(negedge clk);
      checkOutput("busy_idle_before_start", busy, 0);
      start = 1'b1;
      mode = m;
      k = ecount;
      cnt = modelCount(m, a, b, k);
      expRes = (cnt == N) ? 15 : (cnt >> 4);
      expOvf = (cnt == N) ? 1 : 0;
      c = 0;
      seen = 0;
      while (!seen && c < LAT + 20) begin
         @(negedge clk);
         c++;
         start = 1'b0;
         if (c <= W) begin
            ser_a = a[c-1];
            ser_b = b[c-1];
         end
         if (noise && c > W + 5 && c < LAT - 3) start = 1'($urandom_range(0, 1));
         if (c == 1) begin
            checkOutput("busy_rise", busy, 1);
            checkOutput("valid_low_load", valid, 0);
         end
         if (c == LAT - 1) begin
            checkOutput("result_hold", result, prevResult);
            checkOutput("ovf_hold", ovf, prevOvf);
            checkOutput("valid_early", valid, 0);
         end
         if (valid) begin
            seen = 1;
            checkOutput("latency", c, LAT);
            checkOutput("result", result, expRes);
            checkOutput("ovf", ovf, expOvf);
            checkOutput("busy_done", busy, 1);
         end
      end
      if (!seen) checkOutput("valid_timeout", 0, 1);
      prevResult = expRes;
      prevOvf = expOvf;
      if (noise) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         checkOutput("valid_single", valid, 0);
         checkOutput("busy_fall", busy, 0);
         @(negedge clk);
         checkOutput("start_in_done_ignored", busy, 0);
         checkOutput("result_after_done", result, prevResult);
      end
   endtask

   task automatic resetMidRun();
      @(negedge clk);
      start = 1'b1;
      mode = 2'b00;
      ser_a = 1'b1;
      ser_b = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_result", result, 0);
      checkOutput("rst_ovf", ovf, 0);
      checkOutput("rst_valid", valid, 0);
      checkOutput("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      prevResult = 0;
      prevOvf = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_ovf", ovf, 0);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_busy", busy, 0);
      rst_n = 1'b1;

      applyStimulus(2'b00, 0, 15, 1'b0);
      applyStimulus(2'b01, 0, 0, 1'b0);
      applyStimulus(2'b10, 0, 0, 1'b0);
      applyStimulus(2'b00, 8, 8, 1'b0);
      applyStimulus(2'b10, 0, 15, 1'b0);
      applyStimulus(2'b00, 15, 15, 1'b1);
      applyStimulus(2'b01, 0, 0, 1'b0);
      resetMidRun();
      applyStimulus(2'b00, 5, 9, 1'b0);
      applyStimulus(2'b01, 12, 3, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
